// File: rtl/negate_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : negate_sequencer
// Description : Shares one WIDTH-bit two's-complement negator across an operand
//               pair and returns {-op1, -op2} on a valid/ready output.
// Revision    : 1.0 - initial release
// ============================================================================
module negate_sequencer #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [WIDTH-1:0]     op1_i,
    input  logic [WIDTH-1:0]     op2_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic [1:0]           ovf_o,
    output logic                 busy_o,
    output logic [CNT_W-1:0]     done_cnt_o
);

    localparam logic [WIDTH-1:0] C_MIN     = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] C_ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_NEG1 = 2'd1,
        S_NEG2 = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               state_q;
    logic [WIDTH-1:0]     op1_q;
    logic [WIDTH-1:0]     op2_q;
    logic [2*WIDTH-1:0]   result_q;
    logic [1:0]           ovf_q;
    logic                 out_valid_q;
    logic                 busy_q;
    logic [CNT_W-1:0]     done_cnt_q;

    logic [WIDTH-1:0]     neg_in;
    logic [WIDTH-1:0]     neg_d;
    logic                 neg_min_d;
    logic                 in_ready;
    logic                 accept;
    logic                 deliver;

    // The single shared negator: its operand is steered by the sequencing state.
    assign neg_in    = (state_q == S_NEG1) ? op1_q : op2_q;
    assign neg_d     = ~neg_in + C_ONE;
    assign neg_min_d = (neg_in == C_MIN);

    assign in_ready = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready_i);
    assign accept   = in_valid_i & in_ready;
    assign deliver  = out_valid_q & out_ready_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op1_q       <= '0;
            op2_q       <= '0;
            result_q    <= '0;
            ovf_q       <= 2'b00;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_cnt_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        op1_q   <= op1_i;
                        op2_q   <= op2_i;
                        busy_q  <= 1'b1;
                        state_q <= S_NEG1;
                    end
                end
                S_NEG1: begin
                    result_q[2*WIDTH-1:WIDTH] <= neg_d;
                    ovf_q[1]                  <= neg_min_d;
                    state_q                   <= S_NEG2;
                end
                S_NEG2: begin
                    result_q[WIDTH-1:0] <= neg_d;
                    ovf_q[0]            <= neg_min_d;
                    out_valid_q         <= 1'b1;
                    state_q             <= S_DONE;
                end
                S_DONE: begin
                    if (deliver) begin
                        done_cnt_q  <= done_cnt_q + C_CNT_ONE;
                        out_valid_q <= 1'b0;
                        // A waiting pair is taken in the delivery cycle to avoid an IDLE bubble.
                        if (accept) begin
                            op1_q   <= op1_i;
                            op2_q   <= op2_i;
                            state_q <= S_NEG1;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready;
    assign out_valid_o = out_valid_q;
    assign result_o    = result_q;
    assign ovf_o       = ovf_q;
    assign busy_o      = busy_q;
    assign done_cnt_o  = done_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_negate_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_negate_sequencer
// Description : Randomized scoreboard bench for negate_sequencer (WIDTH=16, CNT_W=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_negate_sequencer;

    localparam int WIDTH = 16;
    localparam int CNT_W = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [WIDTH-1:0]    op1 = '0;
    logic [WIDTH-1:0]    op2 = '0;
    logic                out_valid;
    logic                out_ready = 1'b1;
    logic [2*WIDTH-1:0]  result;
    logic [1:0]          ovf;
    logic                busy;
    logic [CNT_W-1:0]    done_cnt;

    negate_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .op1_i       (op1),
        .op2_i       (op2),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .result_o    (result),
        .ovf_o       (ovf),
        .busy_o      (busy),
        .done_cnt_o  (done_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2*WIDTH-1:0] res;
        logic [1:0]         ovf;
        int                 acc;
    } exp_t;

    exp_t q[$];
    int   dq[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   model_cnt = 0;
    bit   post_rst = 1'b0;
    bit   rand_ready = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference arithmetic: negation modulo 2^WIDTH.
    function automatic logic [WIDTH-1:0] neg_ref(input logic [WIDTH-1:0] a);
        int unsigned v;
        v = (65536 - int'(a)) % 65536;
        return v[WIDTH-1:0];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        $display("FAIL %s: timed out (cycle %0d)", name, cyc);
    endtask

    always begin
        @(negedge clk);
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end

    // Monitor: an outstanding pair is busy from the cycle after acceptance and valid 3 cycles after.
    always begin
        bit exp_busy;
        bit exp_valid;
        @(negedge clk);
        #2;
        if (rst) begin
            q.delete();
            model_cnt = 0;
            post_rst  = 1'b1;
        end else begin
            if (post_rst) begin
                chk("reset_result", 64'(result), 64'd0);
                chk("reset_ovf", 64'(ovf), 64'd0);
                post_rst = 1'b0;
            end
            exp_busy  = (q.size() > 0) && (q[0].acc < cyc);
            exp_valid = (q.size() > 0) && ((cyc - q[0].acc) >= 3);
            chk("busy", 64'(busy), 64'(exp_busy));
            chk("out_valid", 64'(out_valid), 64'(exp_valid));
            chk("in_ready", 64'(in_ready), 64'(!exp_busy || (exp_valid && out_ready)));
            chk("done_cnt", 64'(done_cnt), 64'(model_cnt % 16));
            if (exp_valid && out_valid) begin
                chk("result", 64'(result), 64'(q[0].res));
                chk("ovf", 64'(ovf), 64'(q[0].ovf));
                if (out_ready) begin
                    void'(q.pop_front());
                    model_cnt++;
                    dq.push_back(cyc);
                end
            end
        end
    end

    task automatic send_pair(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int   waited;
        exp_t e;
        waited = 0;
        @(negedge clk);
        in_valid = 1'b1;
        op1 = a;
        op2 = b;
        #1;
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!in_ready) begin
            timeout_fail("accept_wait");
            in_valid = 1'b0;
            return;
        end
        e.res = {neg_ref(a), neg_ref(b)};
        e.ovf = {a == 16'h8000, b == 16'h8000};
        e.acc = cyc;
        q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op1 = 16'($urandom);
        op2 = 16'($urandom);
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (q.size() != 0 && w < 500) begin
            @(negedge clk);
            w++;
        end
        if (q.size() != 0) timeout_fail("drain");
    endtask

    task automatic reset_idle();
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [WIDTH-1:0] pick_op();
        case ($urandom_range(0, 5))
            0: return 16'h8000;
            1: return 16'h0000;
            2: return 16'hFFFF;
            3: return 16'h0001;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        int w;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Basic pair
        send_pair(16'h0005, 16'hFFFD);
        drain();
        #1;
        chk("t1_done_cnt", 64'(done_cnt), 64'd1);

        // Most-negative operands
        send_pair(16'h8000, 16'h0000);
        send_pair(16'h0001, 16'h8000);
        drain();

        // Backpressure with operand churn
        out_ready = 1'b0;
        send_pair(16'h1234, 16'h8000);
        w = 0;
        do begin
            @(negedge clk);
            #1;
            w++;
        end while (!out_valid && w < 50);
        if (!out_valid) timeout_fail("bp_valid_wait");
        repeat (5) begin
            @(negedge clk);
            in_valid = 1'b1;
            op1 = 16'($urandom);
            op2 = 16'($urandom);
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        send_pair(16'h7FFF, 16'hFFFF);
        drain();

        // Back-to-back throughput
        reset_idle();
        dq.delete();
        send_pair(16'h0003, 16'h0004);
        send_pair(16'h8000, 16'h8000);
        send_pair(16'hFFFF, 16'h0000);
        send_pair(16'h4000, 16'hC000);
        drain();
        #1;
        chk("t4_done_cnt", 64'(done_cnt), 64'd4);
        if (dq.size() == 4) begin
            for (int i = 0; i < 3; i++) chk("t4_spacing", 64'(dq[i+1] - dq[i]), 64'd3);
        end else begin
            chk("t4_deliveries", 64'(dq.size()), 64'd4);
        end

        // Reset while the second operand is being negated
        send_pair(16'h00AA, 16'h0055);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        send_pair(16'h0010, 16'hFFF0);
        drain();

        // Random traffic with random backpressure
        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            send_pair(pick_op(), pick_op());
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain();
        @(negedge clk);
        rand_ready = 1'b0;
        out_ready = 1'b1;

        // Counter wrap: 17 deliveries on a 4-bit counter
        reset_idle();
        for (int i = 0; i < 17; i++) send_pair(pick_op(), pick_op());
        drain();
        #1;
        chk("t6_done_cnt_wrap", 64'(done_cnt), 64'd1);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
